// File: rtl/fir_hls_mac_pkg.sv
// Shared types, constants and arithmetic helpers for the FIR_HLS pipelined MAC.
package fir_hls_mac_pkg;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_ACC = 1'b1
   } mode_e;

   localparam int unsigned NUM_STAGE_MIN = 1;
   localparam int unsigned NUM_STAGE_MAX = 4;

   // Working width for scaling and range reduction; covers any legal ACC_W + 1.
   localparam int unsigned WIDE_W = 128;

   // Sideband carried alongside each product through the multiplier pipeline.
   typedef struct packed {
      logic first;
      logic last;
   } side_t;

   function automatic logic signed [WIDE_W-1:0] round_shift(
      input logic signed [WIDE_W-1:0] x,
      input int unsigned              sh
   );
      logic signed [WIDE_W-1:0] bias;
      bias = '0;
      if (sh != 0) bias = WIDE_W'(1) <<< (sh - 1);
      return (x + bias) >>> sh;
   endfunction

   // Reduce x to a signed w-bit range: clamp when sat is set, else two's-complement wrap.
   function automatic logic signed [WIDE_W-1:0] fit_width(
      input  logic signed [WIDE_W-1:0] x,
      input  int unsigned              w,
      input  logic                     sat,
      output logic                     clamped
   );
      logic signed [WIDE_W-1:0] hi;
      logic signed [WIDE_W-1:0] lo;
      logic signed [WIDE_W-1:0] r;
      hi      = (WIDE_W'(1) <<< (w - 1)) - WIDE_W'(1);
      lo      = ~hi;
      clamped = 1'b0;
      r       = (x <<< (WIDE_W - w)) >>> (WIDE_W - w);
      if (sat) begin
         r = x;
         if (x > hi) begin
            r       = hi;
            clamped = 1'b1;
         end else if (x < lo) begin
            r       = lo;
            clamped = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_hls_mac_pipe_mul.sv
// Signed multiplier with NUM_STAGE enable-gated registers and a valid/sideband tag.
module fir_hls_mul_pipe
   import fir_hls_mac_pkg::*;
#(
   parameter int unsigned A_W       = 32,
   parameter int unsigned B_W       = 10,
   parameter int unsigned NUM_STAGE = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic               vld_i,
   input  logic [A_W-1:0]     a_i,
   input  logic [B_W-1:0]     b_i,
   input  side_t              side_i,
   output logic               vld_o,
   output side_t              side_o,
   output logic [A_W+B_W-1:0] p_o
);

   localparam int unsigned P_W    = A_W + B_W;
   localparam int unsigned STG_W  = 1 + $bits(side_t) + P_W;
   localparam int unsigned PIPE_W = NUM_STAGE * STG_W;

   logic signed [P_W-1:0] prod_c;
   logic [STG_W-1:0]      new_stg;
   logic [PIPE_W-1:0]     stg_q;
   logic [PIPE_W-1:0]     stg_d;

   assign prod_c  = P_W'($signed(a_i)) * P_W'($signed(b_i));
   assign new_stg = {vld_i, side_i, prod_c};

   // Stage 0 sits in the low bits; the oldest stage falls off the top.
   always_comb begin
      stg_d = stg_q;
      if (en_i) stg_d = PIPE_W'({stg_q, new_stg});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stg_q <= '0;
      else        stg_q <= stg_d;
   end

   assign {vld_o, side_o, p_o} = stg_q[PIPE_W-1 -: STG_W];

endmodule

// File: rtl/fir_hls_mac_pipe.sv
// Pipelined signed multiply / multiply-accumulate with valid/ready stall and rounding scale.
// Build option FIR_HLS_MAC_SAT_EN: saturate accumulator and output, raising sticky ovf.
module fir_hls_mac_pipe
   import fir_hls_mac_pkg::*;
#(
   parameter int unsigned A_W       = 32,
   parameter int unsigned B_W       = 10,
   parameter int unsigned ACC_W     = 48,
   parameter int unsigned DOUT_W    = 32,
   parameter int unsigned SHIFT     = 10,
   parameter int unsigned NUM_STAGE = 2
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [A_W-1:0]    din0,
   input  logic [B_W-1:0]    din1,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic              acc_mode,
   output logic [DOUT_W-1:0] dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ovf
);

   localparam int unsigned P_W    = A_W + B_W;
   localparam int unsigned STAGES = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                                    (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;
`ifdef FIR_HLS_MAC_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   logic                     adv, fire, rdy_q;
   logic                     open_q, open_d;
   mode_e                    mode_q, mode_d, mode_eff;
   side_t                    side_in, m_side;
   logic                     m_vld;
   logic [P_W-1:0]           m_p;
   logic signed [ACC_W-1:0]  acc_q, acc_d, acc_base, acc_sum;
   logic                     acc_clamp, out_clamp;
   logic [DOUT_W-1:0]        out_val;
   logic [DOUT_W-1:0]        dout_q, dout_d;
   logic                     out_valid_q, out_valid_d;
   logic                     ovf_q, ovf_d;

   // A held output freezes the whole pipeline; nothing is accepted until reset has released.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = rdy_q && adv;
   assign fire     = in_valid && in_ready;

   // Mode is latched on the first beat of a packet; multiply beats are always first and last.
   assign mode_eff     = open_q ? mode_q : mode_e'(acc_mode);
   assign side_in.first = !open_q;
   assign side_in.last  = (mode_eff == MODE_MUL) || in_last;

   fir_hls_mul_pipe #(
      .A_W       (A_W),
      .B_W       (B_W),
      .NUM_STAGE (STAGES)
   ) u_mul (
      .clk    (ap_clk),
      .rst_n  (ap_rst_n),
      .en_i   (adv),
      .vld_i  (fire),
      .a_i    (din0),
      .b_i    (din1),
      .side_i (side_in),
      .vld_o  (m_vld),
      .side_o (m_side),
      .p_o    (m_p)
   );

   // Accumulate the product leaving the pipe, then round, shift and fit to the output width.
   always_comb begin
      acc_clamp = 1'b0;
      out_clamp = 1'b0;
      acc_base  = m_side.first ? '0 : acc_q;
      acc_sum   = ACC_W'(fit_width(WIDE_W'($signed(m_p)) + WIDE_W'(acc_base),
                                   ACC_W, SAT_EN, acc_clamp));
      out_val   = DOUT_W'(fit_width(round_shift(WIDE_W'(acc_sum), SHIFT),
                                    DOUT_W, SAT_EN, out_clamp));
   end

   always_comb begin
      open_d      = open_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      dout_d      = dout_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;
      if (fire) begin
         if (!open_q) mode_d = mode_e'(acc_mode);
         open_d = (mode_eff == MODE_ACC) && !in_last;
      end
      if (adv) begin
         out_valid_d = m_vld && m_side.last;
         if (m_vld) begin
            if (m_side.last) begin
               dout_d = out_val;
               acc_d  = '0;
            end else begin
               acc_d  = acc_sum;
            end
            if (acc_clamp || (m_side.last && out_clamp)) ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rdy_q       <= 1'b0;
         open_q      <= 1'b0;
         mode_q      <= MODE_MUL;
         acc_q       <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         rdy_q       <= 1'b1;
         open_q      <= open_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign dout      = dout_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_hls_mac_pipe.sv
// Bench for fir_hls_mac_pipe: two instances (SHIFT=0, SHIFT=10) checked against a transaction model.
module tb_fir_hls_mac_pipe;

   localparam int NS = 2;
`ifdef FIR_HLS_MAC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic signed [63:0] d;
      logic               ovf;
   } exp_t;

   logic               ap_clk;
   logic               ap_rst_n, in_valid, in_last, acc_mode, out_ready;
   logic signed [31:0] din0;
   logic signed [9:0]  din1;
   logic signed [31:0] dout_w [2];
   logic               rdy_w [2];
   logic               ov_w [2];
   logic               ovf_w [2];

   int     ncmp = 0;
   int     nerr = 0;
   int     cyc = 0;
   int     acc_cyc = 0;
   int     out_cyc = 0;
   bit     bp_en = 0;
   int     bp_cnt = 0;

   bit     m_open, m_mode;
   longint m_sum;
   bit     m_ovf [2];
   exp_t   q [2][$];
   longint lg [2][$];

   fir_hls_mac_pipe #(.SHIFT(0)) u_s0 (
      .ap_clk (ap_clk), .ap_rst_n (ap_rst_n), .din0 (din0), .din1 (din1),
      .in_valid (in_valid), .in_ready (rdy_w[0]), .in_last (in_last), .acc_mode (acc_mode),
      .dout (dout_w[0]), .out_valid (ov_w[0]), .out_ready (out_ready), .ovf (ovf_w[0])
   );

   fir_hls_mac_pipe #(.SHIFT(10)) u_s10 (
      .ap_clk (ap_clk), .ap_rst_n (ap_rst_n), .din0 (din0), .din1 (din1),
      .in_valid (in_valid), .in_ready (rdy_w[1]), .in_last (in_last), .acc_mode (acc_mode),
      .dout (dout_w[1]), .out_valid (ov_w[1]), .out_ready (out_ready), .ovf (ovf_w[1])
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   initial forever begin
      @(posedge ap_clk);
      cyc++;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      ncmp++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // Signed range reduction to w bits: clamp or wrap depending on the build.
   function automatic longint fitw(input longint x, input int w, inout bit cl);
      longint hi, lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      if (SAT) begin
         if (x > hi) begin cl = 1'b1; return hi; end
         if (x < lo) begin cl = 1'b1; return lo; end
         return x;
      end
      return (x <<< (64 - w)) >>> (64 - w);
   endfunction

   function automatic void emit(input longint v);
      for (int k = 0; k < 2; k++) begin
         int     sh;
         longint r;
         bit     cl;
         exp_t   e;
         sh = (k == 0) ? 0 : 10;
         cl = 1'b0;
         r  = v + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
         r  = r >>> sh;
         r  = fitw(r, 32, cl);
         if (cl) m_ovf[k] = 1'b1;
         e.d   = r;
         e.ovf = m_ovf[k];
         q[k].push_back(e);
      end
   endfunction

   function automatic void model_beat(input longint a, input longint b, input bit mode, input bit last);
      longint p, s;
      bit     first, eff, cl;
      p     = a * b;
      first = !m_open;
      eff   = m_open ? m_mode : mode;
      if (!m_open) m_mode = mode;
      cl = 1'b0;
      if (!eff) begin
         emit(p);
      end else begin
         s = first ? p : m_sum + p;
         s = fitw(s, 48, cl);
         if (cl) begin m_ovf[0] = 1'b1; m_ovf[1] = 1'b1; end
         if (last) begin emit(s); m_open = 1'b0; end
         else begin m_sum = s; m_open = 1'b1; end
      end
   endfunction

   // Single compare process: every valid output is checked against the model queue head.
   initial forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
         m_open = 1'b0; m_mode = 1'b0; m_sum = 0;
         m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
         q[0].delete(); q[1].delete();
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (ov_w[k]) begin
               if (q[k].size() == 0) begin
                  chk($sformatf("pending_outputs_s%0d", k), q[k].size(), 1);
               end else begin
                  chk($sformatf("dout_s%0d", k), dout_w[k], q[k][0].d);
                  chk($sformatf("ovf_s%0d", k), ovf_w[k], q[k][0].ovf);
                  if (out_ready) begin
                     lg[k].push_back(longint'(dout_w[k]));
                     void'(q[k].pop_front());
                     out_cyc = cyc;
                  end
               end
            end
         end
         if (in_valid && rdy_w[0]) begin
            model_beat(din0, din1, acc_mode, in_last);
            acc_cyc = cyc;
         end
      end
   end

   initial forever begin
      @(posedge ap_clk);
      #1;
      if (bp_en) begin
         out_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
         bp_cnt++;
      end
   end

   task automatic send(input longint a, input longint b, input bit mode, input bit last);
      bit ok;
      din0 = 32'(a); din1 = 10'(b); acc_mode = mode; in_last = last; in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge ap_clk);
         if (rdy_w[0]) begin ok = 1'b1; break; end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge ap_clk);
      #1;
   endtask

   task automatic clr_logs();
      lg[0].delete(); lg[1].delete();
   endtask

   task automatic chk_log(input int k, input string nm, input longint e[$]);
      chk({nm, "_count"}, lg[k].size(), e.size());
      if (lg[k].size() == e.size())
         foreach (e[i]) chk($sformatf("%s_%0d", nm, i), lg[k][i], e[i]);
   endtask

   initial begin
      longint e[$];
      ap_rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_mode = 1'b0;
      din0 = '0; din1 = '0; out_ready = 1'b1;
      repeat (3) @(posedge ap_clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_out_valid_s%0d", k), ov_w[k], 0);
         chk($sformatf("rst_dout_s%0d", k), dout_w[k], 0);
         chk($sformatf("rst_ovf_s%0d", k), ovf_w[k], 0);
         chk($sformatf("rst_in_ready_s%0d", k), rdy_w[k], 0);
      end
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("in_ready_after_rst", rdy_w[0], 1);

      // Single multiply: value and latency
      clr_logs();
      send(1000, -3, 0, 0);
      drain(10);
      e = {-3000};       chk_log(0, "t1_s0", e);
      e = {-3};          chk_log(1, "t1_s10", e);
      chk("t1_latency", out_cyc - acc_cyc, NS + 1);

      // Round-half-up at SHIFT=10
      clr_logs();
      send(1536, 2, 0, 0); send(1536, 1, 0, 0); send(1536, -1, 0, 0);
      drain(10);
      e = {3, 2, -1};              chk_log(1, "t2_s10", e);
      e = {3072, 1536, -1536};     chk_log(0, "t2_s0", e);

      // Four-beat accumulate packet (mode changes mid-packet ignored), then a multiply
      clr_logs();
      send(2, 5, 1, 0); send(-2, 2, 0, 0); send(7, 1, 0, 0); send(10, 10, 0, 1);
      send(5, 5, 0, 0);
      drain(10);
      e = {113, 25};     chk_log(0, "t3_s0", e);
      e = {0, 0};        chk_log(1, "t3_s10", e);

      // Backpressure with out_ready pattern 1,0,0,1
      clr_logs();
      bp_cnt = 0; bp_en = 1'b1;
      for (int i = 0; i < 8; i++) send(longint'((i + 1) * 1000), longint'(i - 3), 0, 0);
      drain(40);
      bp_en = 1'b0; out_ready = 1'b1;
      e.delete();
      for (int i = 0; i < 8; i++) e.push_back(longint'((i + 1) * 1000 * (i - 3)));
      chk_log(0, "t4_s0", e);

      // Large accumulate: saturates or wraps depending on the build
      clr_logs();
      send(32'h7FFFFFFF, 511, 1, 0); send(32'h7FFFFFFF, 511, 1, 0); send(32'h7FFFFFFF, 511, 1, 1);
      drain(10);
      e = {SAT ? longint'(2147483647) : longint'(-1080033281)};
      chk_log(1, "t5_s10", e);
      chk("t5_ovf_s10", ovf_w[1], SAT);
      drain(5);
      chk("t5_ovf_sticky_s10", ovf_w[1], SAT);
      chk("t5_ovf_sticky_s0", ovf_w[0], SAT);

      // Reset in the middle of an accumulate packet
      clr_logs();
      send(4, 4, 1, 0); send(5, 5, 1, 0);
      #2 ap_rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("t6_rst_out_valid_s%0d", k), ov_w[k], 0);
         chk($sformatf("t6_rst_ovf_s%0d", k), ovf_w[k], 0);
      end
      repeat (2) @(posedge ap_clk);
      #1 ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      clr_logs();
      send(3, 3, 1, 1);
      drain(10);
      e = {9};   chk_log(0, "t6_s0", e);
      e = {0};   chk_log(1, "t6_s10", e);

      chk("leftover_s0", q[0].size(), 0);
      chk("leftover_s10", q[1].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
